// File: rtl/ds2_txn_scheduler.sv
// DualShock2 frame scheduler: analog-mode init, one poll per vsync edge, reply decode, watchdog.
// Optional feature macro DS2_RUMBLE_EN: rumble inputs, MOTOR init packet, rumble bytes in POLL.
module ds2_txn_scheduler #(
    parameter int ATT_SETUP   = 16,
    parameter int BYTE_GAP    = 32,
    parameter int WDOG_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    output logic        byte_req,
    output logic [7:0]  byte_tx,
    input  logic        byte_done,
    input  logic [7:0]  byte_rx,
`ifdef DS2_RUMBLE_EN
    input  logic        rumble_small,
    input  logic [7:0]  rumble_large,
`endif
    output logic        ds2_att,
    output logic [15:0] buttons,
    output logic [7:0]  stick_lx,
    output logic [7:0]  stick_ly,
    output logic [7:0]  stick_rx,
    output logic [7:0]  stick_ry,
    output logic        data_valid,
    output logic        pad_present
);
    typedef enum logic [2:0] {
        ST_INIT_START, ST_IDLE, ST_ATT_LOW, ST_WAIT, ST_GAP, ST_ATT_HIGH, ST_FIN
    } state_e;
    typedef enum logic [2:0] {PK_ENTER, PK_ANALOG, PK_MOTOR, PK_EXIT, PK_POLL} pkt_e;

    function automatic logic [7:0] tx_byte(input pkt_e p, input logic [3:0] i,
                                           input logic [7:0] r3, input logic [7:0] r4);
        logic [7:0] b;
        b = 8'h00;
        if (i == 4'd0) begin
            b = 8'h01;
        end else begin
            case (p)
                PK_ENTER:  if (i == 4'd1) b = 8'h43; else if (i == 4'd3) b = 8'h01;
                PK_ANALOG: if (i == 4'd1) b = 8'h44; else if (i == 4'd3) b = 8'h01;
                           else if (i == 4'd4) b = 8'h03;
                PK_MOTOR:  if (i == 4'd1) b = 8'h4D; else if (i == 4'd4) b = 8'h01;
                           else if (i >= 4'd5) b = 8'hFF;
                PK_EXIT:   if (i == 4'd1) b = 8'h43; else if (i >= 4'd4) b = 8'h5A;
                PK_POLL:   if (i == 4'd1) b = 8'h42; else if (i == 4'd3) b = r3;
                           else if (i == 4'd4) b = r4;
                default:   b = 8'h00;
            endcase
        end
        return b;
    endfunction

    function automatic logic [3:0] pkt_len(input pkt_e p);
        return (p == PK_ENTER) ? 4'd5 : 4'd9;
    endfunction

    function automatic pkt_e next_init(input pkt_e p);
        case (p)
            PK_ENTER:  return PK_ANALOG;
`ifdef DS2_RUMBLE_EN
            PK_ANALOG: return PK_MOTOR;
`endif
            default:   return PK_EXIT;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] rmb3_in, rmb4_in;
`ifdef DS2_RUMBLE_EN
    assign rmb3_in = rumble_small ? 8'hFF : 8'h00;
    assign rmb4_in = rumble_large;
`else
    assign rmb3_in = 8'h00;
    assign rmb4_in = 8'h00;
`endif

    state_e      state_q, state_d;
    pkt_e        pkt_q, pkt_d, start_pkt;
    logic        start;
    logic [7:0]  cnt_q, cnt_d, err_q, err_d;
    logic [3:0]  idx_q, idx_d, len_q, len_d;
    logic        ok_q, ok_d, pending_q, pending_d, vs_q;
    logic        att_q, att_d, req_q, req_d, dv_q, dv_d, present_q, present_d;
    logic [7:0]  tx_q, tx_d, rmb3_q, rmb3_d, rmb4_q, rmb4_d;
    logic [15:0] buttons_q, buttons_d;
    logic [7:0]  lx_q, lx_d, ly_q, ly_d, rx_q, rx_d, ry_q, ry_d;
    logic [7:0]  rxb_q [3:8];
    logic        vs_edge;

    assign vs_edge = vsync & ~vs_q;

    always_comb begin
        state_d   = state_q;   pkt_d     = pkt_q;     cnt_d  = cnt_q;  idx_d = idx_q;
        len_d     = len_q;     ok_d      = ok_q;      err_d  = err_q;  att_d = att_q;
        pending_d = pending_q; present_d = present_q; tx_d   = tx_q;
        buttons_d = buttons_q; lx_d = lx_q; ly_d = ly_q; rx_d = rx_q; ry_d = ry_q;
        rmb3_d    = rmb3_q;    rmb4_d    = rmb4_q;
        req_d     = 1'b0;      dv_d      = 1'b0;
        start     = 1'b0;      start_pkt = PK_ENTER;

        // Edges arriving while busy are remembered once; extras are dropped.
        if (vs_edge && state_q != ST_IDLE) pending_d = 1'b1;

        case (state_q)
            ST_INIT_START: start = 1'b1;
            ST_IDLE: if (vs_edge || pending_q) begin
                start     = 1'b1;
                start_pkt = PK_POLL;
                pending_d = 1'b0;
                rmb3_d    = rmb3_in;
                rmb4_d    = rmb4_in;
            end
            ST_ATT_LOW: if (cnt_q == 8'(ATT_SETUP - 1)) begin
                state_d = ST_WAIT;
                req_d   = 1'b1;
                tx_d    = tx_byte(pkt_q, idx_q, rmb3_q, rmb4_q);
            end else cnt_d = cnt_q + 8'd1;
            ST_WAIT: if (byte_done) begin
                // Poll length comes from the ID nibble before byte2 is requested.
                if (pkt_q == PK_POLL && idx_q == 4'd1) begin
                    if (byte_rx[3:0] == 4'd0 || byte_rx[3:0] > 4'd3) begin
                        len_d = 4'd3;
                        ok_d  = 1'b0;
                    end else len_d = 4'd3 + {byte_rx[2:0], 1'b0};
                end
                if (idx_q == 4'd2 && byte_rx != 8'h5A) ok_d = 1'b0;
                cnt_d = 8'd0;
                if (idx_q == len_d - 4'd1) begin
                    state_d = ST_ATT_HIGH;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_GAP;
                    idx_d   = idx_q + 4'd1;
                end
            end
            ST_GAP: if (cnt_q == 8'(BYTE_GAP - 1)) begin
                state_d = ST_WAIT;
                req_d   = 1'b1;
                tx_d    = tx_byte(pkt_q, idx_q, rmb3_q, rmb4_q);
            end else cnt_d = cnt_q + 8'd1;
            ST_ATT_HIGH: if (cnt_q >= 8'(ATT_SETUP - 1)) begin
                state_d = ST_FIN;
                att_d   = 1'b1;
            end else cnt_d = cnt_q + 8'd1;
            ST_FIN: if (pkt_q != PK_POLL) begin
                if (!ok_q) start = 1'b1;
                else if (pkt_q == PK_EXIT) state_d = ST_IDLE;
                else begin
                    start     = 1'b1;
                    start_pkt = next_init(pkt_q);
                end
            end else if (ok_q) begin
                buttons_d = ~{rxb_q[4], rxb_q[3]};
                rx_d      = (len_q >= 4'd7) ? rxb_q[5] : 8'h80;
                ry_d      = (len_q >= 4'd7) ? rxb_q[6] : 8'h80;
                lx_d      = (len_q == 4'd9) ? rxb_q[7] : 8'h80;
                ly_d      = (len_q == 4'd9) ? rxb_q[8] : 8'h80;
                dv_d      = 1'b1;
                err_d     = 8'd0;
                present_d = 1'b1;
                state_d   = ST_IDLE;
            end else if ({1'b0, err_q} + 9'd1 >= 9'(WDOG_FRAMES)) begin
                present_d = 1'b0;
                err_d     = 8'd0;
                state_d   = ST_INIT_START;
            end else begin
                err_d   = sat_inc(err_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_START;
        endcase

        if (start) begin
            state_d = ST_ATT_LOW;
            pkt_d   = start_pkt;
            att_d   = 1'b0;
            cnt_d   = 8'd0;
            idx_d   = 4'd0;
            ok_d    = 1'b1;
            len_d   = pkt_len(start_pkt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT_START; pkt_q <= PK_ENTER; cnt_q <= 8'd0; idx_q <= 4'd0;
            len_q <= 4'd5; ok_q <= 1'b1; err_q <= 8'd0; pending_q <= 1'b0; vs_q <= 1'b0;
            att_q <= 1'b1; req_q <= 1'b0; tx_q <= 8'h00; dv_q <= 1'b0; present_q <= 1'b0;
            buttons_q <= 16'h0000; lx_q <= 8'h80; ly_q <= 8'h80; rx_q <= 8'h80; ry_q <= 8'h80;
            rmb3_q <= 8'h00; rmb4_q <= 8'h00;
        end else begin
            state_q <= state_d; pkt_q <= pkt_d; cnt_q <= cnt_d; idx_q <= idx_d;
            len_q <= len_d; ok_q <= ok_d; err_q <= err_d; pending_q <= pending_d; vs_q <= vsync;
            att_q <= att_d; req_q <= req_d; tx_q <= tx_d; dv_q <= dv_d; present_q <= present_d;
            buttons_q <= buttons_d; lx_q <= lx_d; ly_q <= ly_d; rx_q <= rx_d; ry_q <= ry_d;
            rmb3_q <= rmb3_d; rmb4_q <= rmb4_d;
        end
    end

    // Reply payload capture; only bytes 3..8 carry data.
    always_ff @(posedge clk) begin
        if (state_q == ST_WAIT && byte_done) begin
            for (int k = 3; k <= 8; k++) begin
                if (idx_q == 4'(k)) rxb_q[k] <= byte_rx;
            end
        end
    end

    assign byte_req    = req_q;
    assign byte_tx     = tx_q;
    assign ds2_att     = att_q;
    assign buttons     = buttons_q;
    assign stick_lx    = lx_q;
    assign stick_ly    = ly_q;
    assign stick_rx    = rx_q;
    assign stick_ry    = ry_q;
    assign data_valid  = dv_q;
    assign pad_present = present_q;
endmodule

// File: tb/tb_ds2_txn_scheduler.sv
// Directed bench for ds2_txn_scheduler (default build): init sequence, polls, watchdog, pending, reset.
module tb_ds2_txn_scheduler;
    logic        clk, rst_n, vsync, byte_done;
    logic [7:0]  byte_rx;
    logic        byte_req, ds2_att, data_valid, pad_present;
    logic [7:0]  byte_tx, stick_lx, stick_ly, stick_rx, stick_ry;
    logic [15:0] buttons;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  tx_log [$];
    logic [7:0]  reply [9];
    logic [7:0]  exp_seq [9];
    int          dv_cnt = 0;
    logic        dv_rise_ok = 1'b0;
    logic        att_p1 = 1'b1, att_p2 = 1'b1;

    ds2_txn_scheduler dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync),
        .byte_req(byte_req), .byte_tx(byte_tx), .byte_done(byte_done), .byte_rx(byte_rx),
        .ds2_att(ds2_att), .buttons(buttons),
        .stick_lx(stick_lx), .stick_ly(stick_ly), .stick_rx(stick_rx), .stick_ry(stick_ry),
        .data_valid(data_valid), .pad_present(pad_present)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int base, input int n);
        logic [31:0] act;
        for (int i = 0; i < n; i++) begin
            act = (base + i < tx_log.size()) ? {24'h0, tx_log[base + i]} : 32'hFFFF_FFFF;
            check($sformatf("%s[%0d]", tag, i), act, {24'h0, exp_seq[i]});
        end
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int c = 0;
        while (tx_log.size() < n && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(tx_log.size()), 32'(n));
    endtask

    task automatic wait_att_high(input string tag);
        int c = 0;
        while (ds2_att !== 1'b1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check(tag, {31'h0, ds2_att}, 32'h1);
    endtask

    task automatic pulse_vsync();
        @(posedge clk); #1 vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_att"}, {31'h0, ds2_att}, 32'h1);
        check({tag, "_req"}, {31'h0, byte_req}, 32'h0);
        check({tag, "_tx"}, {24'h0, byte_tx}, 32'h0);
        check({tag, "_buttons"}, {16'h0, buttons}, 32'h0);
        check({tag, "_sticks"}, {stick_lx, stick_ly, stick_rx, stick_ry}, 32'h80808080);
        check({tag, "_dv"}, {31'h0, data_valid}, 32'h0);
        check({tag, "_present"}, {31'h0, pad_present}, 32'h0);
    endtask

    // Pad / byte engine model: answers each byte_req three cycles later.
    initial begin : pad_model
        int pend, bcount, pidx;
        pend = 0; bcount = 0; pidx = 0;
        byte_done = 1'b0;
        byte_rx = 8'h00;
        forever begin
            @(posedge clk); #1;
            byte_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
                bcount = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        byte_done = 1'b1;
                        byte_rx = (pidx < 9) ? reply[pidx] : 8'h00;
                    end
                end
                if (byte_req) begin
                    tx_log.push_back(byte_tx);
                    pidx = bcount;
                    bcount++;
                    pend = 3;
                end
                if (ds2_att) bcount = 0;
            end
        end
    end

    initial begin : dv_monitor
        forever begin
            @(negedge clk);
            if (data_valid) begin
                dv_cnt++;
                dv_rise_ok = ds2_att && att_p1 && !att_p2;
            end
            att_p2 = att_p1;
            att_p1 = ds2_att;
        end
    end

    initial begin : main
        int base, dvb;
        rst_n = 1'b0;
        vsync = 1'b0;
        reply = '{8'hFF, 8'h73, 8'h5A, 8'h7F, 8'hFE, 8'h10, 8'h20, 8'h30, 8'h40};
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Init: ENTER, ANALOG, EXIT then idle with att high.
        wait_bytes(23, "init_bytes");
        wait_att_high("init_att");
        repeat (60) @(negedge clk);
        exp_seq = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_seq("enter", 0, 5);
        exp_seq = '{8'h01, 8'h44, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        check_seq("analog", 5, 9);
        exp_seq = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        check_seq("exit", 14, 9);
        check("init_no_poll", 32'(tx_log.size()), 32'd23);
        check("init_idle_att", {31'h0, ds2_att}, 32'h1);
        check("init_present", {31'h0, pad_present}, 32'h0);

        // Full analog poll.
        base = tx_log.size(); dvb = dv_cnt;
        pulse_vsync();
        wait_bytes(base + 9, "poll_bytes");
        wait_att_high("poll_att");
        repeat (100) @(negedge clk);
        exp_seq = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_seq("poll_tx", base, 9);
        check("poll_req_count", 32'(tx_log.size() - base), 32'd9);
        check("poll_dv_pulses", 32'(dv_cnt - dvb), 32'd1);
        check("poll_dv_after_att", {31'h0, dv_rise_ok}, 32'h1);
        check("poll_buttons", {16'h0, buttons}, 32'h0180);
        check("poll_sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h10203040);
        check("poll_present", {31'h0, pad_present}, 32'h1);

        // Digital pad: 5-byte poll, sticks centred.
        reply = '{8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFB, 8'h11, 8'h22, 8'h33, 8'h44};
        base = tx_log.size(); dvb = dv_cnt;
        pulse_vsync();
        wait_bytes(base + 5, "dig_bytes");
        wait_att_high("dig_att");
        repeat (100) @(negedge clk);
        exp_seq = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_seq("dig_tx", base, 5);
        check("dig_len", 32'(tx_log.size() - base), 32'd5);
        check("dig_dv_pulses", 32'(dv_cnt - dvb), 32'd1);
        check("dig_buttons", {16'h0, buttons}, 32'h0400);
        check("dig_sticks", {stick_rx, stick_ry, stick_lx, stick_ly}, 32'h80808080);

        // Watchdog: eight bad replies drop pad_present and force re-init.
        reply = '{8'hFF, 8'h73, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dvb = dv_cnt;
        for (int k = 0; k < 8; k++) begin
            base = tx_log.size();
            pulse_vsync();
            wait_bytes(base + 9, $sformatf("wd_bytes_%0d", k));
            wait_att_high($sformatf("wd_att_%0d", k));
            repeat (5) @(negedge clk);
            check($sformatf("wd_present_%0d", k), {31'h0, pad_present}, (k < 7) ? 32'h1 : 32'h0);
        end
        reply = '{8'hFF, 8'h73, 8'h5A, 8'h7F, 8'hFE, 8'h10, 8'h20, 8'h30, 8'h40};
        check("wd_no_dv", 32'(dv_cnt - dvb), 32'd0);
        check("wd_buttons_hold", {16'h0, buttons}, 32'h0400);
        base = tx_log.size();
        wait_bytes(base + 23, "reinit_bytes");
        wait_att_high("reinit_att");
        repeat (60) @(negedge clk);
        exp_seq = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_seq("reinit_enter", base, 5);
        check("reinit_len", 32'(tx_log.size() - base), 32'd23);

        // Two edges during a poll yield exactly one follow-up poll.
        base = tx_log.size(); dvb = dv_cnt;
        pulse_vsync();
        wait_bytes(base + 3, "pend_first");
        pulse_vsync();
        pulse_vsync();
        wait_bytes(base + 18, "pend_bytes");
        wait_att_high("pend_att");
        repeat (300) @(negedge clk);
        check("pend_total", 32'(tx_log.size() - base), 32'd18);
        check("pend_dv_pulses", 32'(dv_cnt - dvb), 32'd2);
        exp_seq = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_seq("pend_second", base + 9, 9);

        // Asynchronous reset in the middle of a byte exchange.
        base = tx_log.size();
        pulse_vsync();
        wait_bytes(base + 1, "rst_first_byte");
        @(posedge clk); #1;
        check("pre_rst_att", {31'h0, ds2_att}, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
